// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the narrow-store path: size encodings, byte-enable
// constants, the store FIFO entry layout and the FIFO occupancy states.
// No ports (package).
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic [29:0] addr;   // word address, byte offset dropped
        logic [31:0] wdata;
        logic [3:0]  be;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } fifo_state_t;

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align
// Combinational lane steering for sb/sh/sw stores.
// Ports:
//   addr[1:0]  in   byte offset of the store
//   size[1:0]  in   SZ_BYTE / SZ_HALF / SZ_WORD / reserved
//   data[31:0] in   register value
//   wdata[31:0] out lane-replicated write data
//   be[3:0]    out  byte enables (bit n = lane n)
//   misaligned out  half at odd address, word not on a word boundary, or reserved size
import mips_mem_pkg::*;

module store_lane_align (
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        be         = BE_WORD;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = BE_BYTE0 << addr;
            end
            SZ_HALF: begin
                // addr[0] is ignored for lane selection: an odd half is
                // either rejected or silently rounded down.
                wdata      = {2{data[15:0]}};
                be         = addr[1] ? BE_HALF_HI : BE_HALF_LO;
                misaligned = addr[0];
            end
            SZ_WORD: begin
                misaligned = (addr != 2'b00);
            end
            default: begin
                // reserved size behaves as a word when it is let through
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_32.sv
// store_narrow_32
// Narrow store unit: aligns sb/sh/sw requests onto 32-bit memory lanes and
// buffers them in a 2-entry in-order FIFO ahead of the data memory port.
// Optional feature macro: STORE_MISALIGN_CHECK_EN (drop misaligned requests
// and pulse misalign_err one cycle after the handshake).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     store request handshake
//   req_addr/data/size      store byte address, register value, width
//   mem_valid/mem_ready     write handshake toward data memory
//   mem_addr/wdata/be       registered write presented from the FIFO head
//   misalign_err            one-cycle pulse for a rejected request
//   busy                    any entry buffered
//
// state    | meaning
// ST_EMPTY | no buffered writes, mem_valid low
// ST_ONE   | one write buffered and presented
// ST_FULL  | two writes buffered, req_ready low
import mips_mem_pkg::*;

module store_narrow_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        misalign_err,
    output logic        busy
);

    fifo_state_t state_q, state_d;
    fifo_entry_t entries_q [2];
    fifo_entry_t new_entry, head_d;
    logic        wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic        accept, push, pop;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic        al_mis;

    store_lane_align u_align (
        .addr       (req_addr[1:0]),
        .size       (req_size),
        .data       (req_data),
        .wdata      (al_wdata),
        .be         (al_be),
        .misaligned (al_mis)
    );

    assign req_ready = (state_q != ST_FULL);
    assign busy      = (state_q != ST_EMPTY);
    assign accept    = req_valid && req_ready;
    assign pop       = mem_valid && mem_ready;
    assign new_entry = '{addr: req_addr[31:2], wdata: al_wdata, be: al_be};

`ifdef STORE_MISALIGN_CHECK_EN
    assign push = accept && !al_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= accept && al_mis;
    end
`else
    logic unused_mis;
    assign unused_mis   = al_mis;
    assign push         = accept;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (push)         state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)       state_d = ST_FULL;
                else if (pop && !push)  state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop)          state_d = ST_ONE;
            default:                    state_d = ST_EMPTY;
        endcase
    end

    // The head after this edge: when the slot being written is also the
    // next read slot, the FIFO was (or becomes) otherwise empty, so the
    // new entry is the head.
    assign rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    assign head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? new_entry : entries_q[rd_ptr_d];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            for (int i = 0; i < 2; i++) entries_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_valid <= (state_d != ST_EMPTY);
            if (push) begin
                entries_q[wr_ptr_q] <= new_entry;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (state_d != ST_EMPTY) begin
                mem_addr  <= {head_d.addr, 2'b00};
                mem_wdata <= head_d.wdata;
                mem_be    <= head_d.be;
            end
        end
    end

endmodule

// File: tb/tb_store_narrow_32.sv
// tb_store_narrow_32
// Directed and randomized checks of store_narrow_32 against a queue-based
// reference model. Build with +define+STORE_MISALIGN_CHECK_EN to match the
// misalignment-checking variant of the design.
module tb_store_narrow_32;

`ifdef STORE_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign_err;
    logic        busy;

    always #5 clk = ~clk;

    store_narrow_32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .misalign_err (misalign_err),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t q[$];
    bit  exp_mis = 1'b0;
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference lane placement, from the store-width rules.
    function automatic wr_t model_align(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] sz, output bit mis);
        wr_t w;
        w.addr = a - (a % 4);
        case (sz)
            2'd0: begin
                w.wdata = (d % 256) * 32'h0101_0101;
                w.be    = 4'(1 << (a % 4));
                mis     = 1'b0;
            end
            2'd1: begin
                w.wdata = (d % 65536) * 32'h0001_0001;
                w.be    = (((a / 2) % 2) == 1) ? 4'hC : 4'h3;
                mis     = ((a % 2) == 1);
            end
            2'd2: begin
                w.wdata = d;
                w.be    = 4'hF;
                mis     = ((a % 4) != 0);
            end
            default: begin
                w.wdata = d;
                w.be    = 4'hF;
                mis     = 1'b1;
            end
        endcase
        return w;
    endfunction

    // One clock: drive inputs at the falling edge, check outputs against the
    // model, then advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic mr);
        bit  acc, pp, mis;
        wr_t w;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        mem_ready = mr;
        #1;
        chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() < 2});
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, q.size() != 0});
        chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("mem_be", {28'b0, mem_be}, {28'b0, q[0].be});
        end
        acc = v && (q.size() < 2);
        pp  = mr && (q.size() != 0);
        w   = model_align(a, d, sz, mis);
        @(posedge clk);
        if (pp) q.delete(0);
        exp_mis = 1'b0;
        if (acc) begin
            if (CHECK_EN && mis) exp_mis = 1'b1;
            else                 q.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 2'd0, mr);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        mem_ready = 1'b0;
        #1;
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // sb to 0x1003
        cycle(1'b1, 32'h1003, 32'h0000_00AB, 2'd0, 1'b1);
        chk("sb_valid", {31'b0, mem_valid}, 32'd1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_be", {28'b0, mem_be}, 32'b1000);
        idle(1, 1'b1);

        // sh to 0x2002, then sw to 0x2004 popping the half in the same cycle
        cycle(1'b1, 32'h2002, 32'h0000_BEEF, 2'd1, 1'b1);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("sh_be", {28'b0, mem_be}, 32'b1100);
        cycle(1'b1, 32'h2004, 32'h1234_5678, 2'd2, 1'b1);
        chk("sw_addr", mem_addr, 32'h2004);
        chk("sw_wdata", mem_wdata, 32'h1234_5678);
        chk("sw_be", {28'b0, mem_be}, 32'b1111);
        idle(2, 1'b1);

        // backpressure: three offers with memory stalled
        cycle(1'b1, 32'h5000, 32'hA1, 2'd0, 1'b0);
        cycle(1'b1, 32'h5005, 32'hB2, 2'd0, 1'b0);
        cycle(1'b1, 32'h500A, 32'hC3C3, 2'd1, 1'b0);
        chk("full_ready", {31'b0, req_ready}, 32'd0);
        chk("full_head_addr", mem_addr, 32'h5000);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
        chk("drain_ready", {31'b0, req_ready}, 32'd1);
        chk("drain_second", mem_addr, 32'h5004);
        idle(2, 1'b1);

        // word to a misaligned address
        cycle(1'b1, 32'h3001, 32'hCAFE_F00D, 2'd2, 1'b1);
        if (CHECK_EN) begin
            chk("mis_pulse", {31'b0, misalign_err}, 32'd1);
            chk("mis_no_write", {31'b0, mem_valid}, 32'd0);
        end else begin
            chk("mis_addr", mem_addr, 32'h3000);
            chk("mis_be", {28'b0, mem_be}, 32'hF);
        end
        idle(2, 1'b1);

        // reset while full and stalled
        cycle(1'b1, 32'h6000, 32'h1111_1111, 2'd2, 1'b0);
        cycle(1'b1, 32'h6004, 32'h2222_2222, 2'd2, 1'b0);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, mem_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        q.delete();
        exp_mis = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b1);

        // one entry held, then accept and pop together
        cycle(1'b1, 32'h4001, 32'h11, 2'd0, 1'b0);
        cycle(1'b1, 32'h4008, 32'h5566_7788, 2'd2, 1'b1);
        chk("swap_busy", {31'b0, busy}, 32'd1);
        chk("swap_ready", {31'b0, req_ready}, 32'd1);
        chk("swap_addr", mem_addr, 32'h4008);
        chk("swap_wdata", mem_wdata, 32'h5566_7788);
        idle(2, 1'b1);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), $urandom, $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_narrow_32.md
STORE_NARROW_32 -- requirements
Module: store_narrow_32

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1, store request present.
REQ-004 SHALL have port req_ready, output, 1, block can accept a request.
REQ-005 SHALL have port req_addr, input, 32, byte address of store.
REQ-006 SHALL have port req_data, input, 32, register value; low byte/half/word is stored.
REQ-007 SHALL have port req_size, input, 2, width: 00 byte (sb), 01 half (sh), 10 word (sw), 11 reserved.
REQ-008 SHALL have port mem_valid, output, 1, write presented to data memory.
REQ-009 SHALL have port mem_ready, input, 1, memory accepts write this cycle.
REQ-010 SHALL have port mem_addr, output, 32, word-aligned address, bits [1:0] = 00.
REQ-011 SHALL have port mem_wdata, output, 32, lane-aligned write data.
REQ-012 SHALL have port mem_be, output, 4, byte enables, bit n = byte lane n (little-endian).
REQ-013 SHALL have port misalign_err, output, 1, one-cycle pulse for a rejected request.
REQ-014 SHALL have port busy, output, 1, high while any entry is buffered.

Function
REQ-015 SHALL accept a request on req_valid && req_ready; req_ready = (count != 2), with no combinational dependence on mem_ready.
REQ-016 SHALL buffer accepted writes in a 2-entry in-order FIFO; count is 0..2.
REQ-017 SHALL hold states EMPTY, ONE and FULL: push only -> up one state; pop only -> down one; push and pop together -> unchanged.
REQ-018 SHALL pop on mem_valid && mem_ready; mem_valid = (count != 0).
REQ-019 SHALL register all mem_* outputs from the FIFO head, so minimum latency from accept to mem_valid is 1 cycle; no same-cycle pass-through.
REQ-020 SHALL keep mem_addr, mem_wdata and mem_be stable while mem_valid && !mem_ready.
REQ-021 SHALL align a byte store as: wdata = req_data[7:0] replicated to all 4 lanes; be = 1 << addr[1:0].
REQ-022 SHALL align a half store as: wdata = {req_data[15:0], req_data[15:0]}; be = 0011 if addr[1] = 0, else 1100.
REQ-023 SHALL align a word store as: wdata = req_data; be = 1111.
REQ-024 SHALL treat as misaligned: half with addr[0] = 1; word with addr[1:0] != 00; size 11.
REQ-025 SHALL wrap the FIFO pointers modulo 2 and never overwrite an unpopped entry.
REQ-026 SHALL set busy = (count != 0).

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear count, pointers, mem_valid, mem_addr, mem_wdata, mem_be and misalign_err to 0; req_ready is 1 after reset.
REQ-028 SHALL discard buffered entries on reset mid-operation; no write is presented after rst_n deasserts until a new request is accepted.

Configuration
REQ-029 SHALL, with macro STORE_MISALIGN_CHECK_EN defined, not enqueue a misaligned request that is handshaken, and pulse misalign_err exactly 1 cycle later.
REQ-030 SHALL, without STORE_MISALIGN_CHECK_EN, tie misalign_err to 0 and enqueue every request: half forces addr[0] to 0, word forces addr[1:0] to 00, size 11 is treated as word.

Structure
REQ-031 SHALL take the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the BE constants and the FIFO entry typedef {addr[31:2], wdata, be} from shared package mips_mem_pkg.
REQ-032 SHALL implement lane alignment in combinational sub-module store_lane_align (inputs addr[1:0], size, data; outputs wdata, be, misaligned).

Verification
REQ-033 SHALL verify: sb, addr 0x1003, data 0x000000AB, mem_ready = 1 -> next cycle mem_addr 0x1000, wdata 0xABABABAB, be 1000.
REQ-034 SHALL verify: sh, addr 0x2002, data 0x0000BEEF -> wdata 0xBEEFBEEF, be 1100; sw, addr 0x2004, data 0x12345678 -> be 1111.
REQ-035 SHALL verify: mem_ready = 0 while 3 requests are offered -> first two accepted, req_ready = 0 on the third; release mem_ready -> in-order drain and req_ready returns to 1 after the first pop.
REQ-036 SHALL verify: with STORE_MISALIGN_CHECK_EN, sw to 0x3001 -> misalign_err pulses 1 cycle, mem_valid stays 0; without it -> write to 0x3000, be 1111.
REQ-037 SHALL verify: full FIFO stalled, rst_n pulsed low for 1 cycle -> mem_valid = 0 and busy = 0 immediately; no stale write appears afterwards.
REQ-038 SHALL verify: count = 1 with simultaneous accept and pop -> count stays 1 and the new entry is presented next cycle.
